// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT complex butterfly with rounding, optional /2 scaling,
// saturation, sticky overflow and a valid/ready handshake with full backpressure.
module butterfly_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] W,
    input  logic             inverse,
    input  logic             scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = WIDTH + 1;   // product-sum width
    localparam int IW   = HALF + 2;    // intermediate component width

    localparam logic signed [PW-1:0] RND  = PW'(1) << (HALF - 2);
    localparam logic signed [IW-1:0] ONE  = IW'(1);
    localparam logic signed [IW-1:0] MAXV = (IW'(1) << (HALF - 1)) - IW'(1);
    localparam logic signed [IW-1:0] MINV = -MAXV - ONE;

    function automatic logic [HALF-1:0] sat_f(input logic signed [IW-1:0] x);
        if (x > MAXV)
            return MAXV[HALF-1:0];
        else if (x < MINV)
            return MINV[HALF-1:0];
        else
            return x[HALF-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Handshake: every stage moves together, so one stall term covers all.
    // ------------------------------------------------------------------
    logic stall;
    logic advance;
    logic v1_reg, v2_reg, v3_reg;

    assign stall     = v3_reg & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;
    assign out_valid = v3_reg;

    // ------------------------------------------------------------------
    // Stage 1: unpack operands and form the four partial products.
    // Component index 0 = real (upper half), 1 = imaginary (lower half).
    // ------------------------------------------------------------------
    logic signed [HALF-1:0]  b_c [2];
    logic signed [HALF-1:0]  w_c [2];
    logic signed [WIDTH-1:0] bx  [2];
    logic signed [WIDTH-1:0] wx  [2];
    logic signed [WIDTH-1:0] p_next [4];
    logic signed [WIDTH-1:0] p_reg  [4];
    logic [WIDTH-1:0]        a1_reg;
    logic                    scale1_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign b_c[gi] = B[(1-gi)*HALF +: HALF];
            assign w_c[gi] = W[(1-gi)*HALF +: HALF];
            assign bx[gi]  = WIDTH'(b_c[gi]);
        end
    endgenerate

    // Conjugation is done after widening so that negating -2^(HALF-1) cannot wrap.
    assign wx[0] = WIDTH'(w_c[0]);
    assign wx[1] = inverse ? -WIDTH'(w_c[1]) : WIDTH'(w_c[1]);

    // p[0]=Br*Wr, p[1]=Br*Wi, p[2]=Bi*Wr, p[3]=Bi*Wi
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prod
            assign p_next[gi] = bx[gi/2] * wx[gi%2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: combine partial products and round back to Q format.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] t_full [2];
    logic signed [PW-1:0] t_rnd  [2];
    logic signed [IW-1:0] t_next [2];
    logic signed [IW-1:0] t_reg  [2];
    logic [WIDTH-1:0]     a2_reg;
    logic                 scale2_reg;
    logic                 unused_round_bits;

    assign t_full[0] = PW'(p_reg[0]) - PW'(p_reg[3]);
    assign t_full[1] = PW'(p_reg[1]) + PW'(p_reg[2]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_round
            assign t_rnd[gi]  = t_full[gi] + RND;
            // Top IW bits equal the arithmetic shift right by HALF-1.
            assign t_next[gi] = t_rnd[gi][PW-1 -: IW];
        end
    endgenerate

    assign unused_round_bits = ^{t_rnd[0][HALF-2:0], t_rnd[1][HALF-2:0]};

    // ------------------------------------------------------------------
    // Stage 3: add/subtract, optional halving, saturate.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out0_next, out1_next;
    logic [WIDTH-1:0] out0_reg, out1_reg;
    logic [3:0]       sat_flag;
    logic             ovf_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addsub
            logic signed [HALF-1:0] a_c;
            logic signed [IW-1:0]   a_x;
            logic signed [IW-1:0]   sum, dif;
            logic signed [IW-1:0]   sum_s, dif_s;

            assign a_c   = a2_reg[(1-gi)*HALF +: HALF];
            assign a_x   = IW'(a_c);
            assign sum   = a_x + t_reg[gi];
            assign dif   = a_x - t_reg[gi];
            assign sum_s = scale2_reg ? ((sum + ONE) >>> 1) : sum;
            assign dif_s = scale2_reg ? ((dif + ONE) >>> 1) : dif;

            assign out0_next[(1-gi)*HALF +: HALF] = sat_f(sum_s);
            assign out1_next[(1-gi)*HALF +: HALF] = sat_f(dif_s);
            assign sat_flag[gi]     = (sum_s > MAXV) || (sum_s < MINV);
            assign sat_flag[gi + 2] = (dif_s > MAXV) || (dif_s < MINV);
        end
    endgenerate

    assign out0 = out0_reg;
    assign out1 = out1_reg;
    assign ovf  = ovf_reg;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            v3_reg     <= 1'b0;
            a1_reg     <= '0;
            a2_reg     <= '0;
            scale1_reg <= 1'b0;
            scale2_reg <= 1'b0;
            for (int i = 0; i < 4; i++) p_reg[i] <= '0;
            for (int i = 0; i < 2; i++) t_reg[i] <= '0;
            out0_reg   <= '0;
            out1_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (advance) begin
                v1_reg     <= in_valid;
                a1_reg     <= A;
                scale1_reg <= scale;
                for (int i = 0; i < 4; i++) p_reg[i] <= p_next[i];

                v2_reg     <= v1_reg;
                a2_reg     <= a1_reg;
                scale2_reg <= scale1_reg;
                for (int i = 0; i < 2; i++) t_reg[i] <= t_next[i];

                v3_reg     <= v2_reg;
                out0_reg   <= out0_next;
                out1_reg   <= out1_next;
            end

            // A fresh saturation entering the output stage beats a clear.
            if (advance && v2_reg && (|sat_flag))
                ovf_reg <= 1'b1;
            else if (ovf_clr)
                ovf_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed literal cases plus randomized streams with
// backpressure, checked every cycle against an arithmetic reference model and an ordered queue.
module tb_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0, B = '0, W = '0;
    logic        inverse = 1'b0;
    logic        scale = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out0, out1;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    always #5 clk = ~clk;

    butterfly_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .W(W),
        .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [31:0] o0;
        logic [31:0] o1;
        bit          sat;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          ovf_acc = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev0 = '0, prev1 = '0;

    function automatic logic [31:0] pk(input int r, input int i);
        logic [15:0] rr, ii;
        rr = r[15:0];
        ii = i[15:0];
        return {rr, ii};
    endfunction

    function automatic longint comp(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    // Reference: exact integer arithmetic on the complex values, then round/scale/saturate.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] w, input bit inv, input bit sc);
        exp_t   e;
        longint ar, ai, br, bi, wr, wi, tr, ti;
        longint x[4];
        logic [63:0] v[4];
        ar = comp(a[31:16]); ai = comp(a[15:0]);
        br = comp(b[31:16]); bi = comp(b[15:0]);
        wr = comp(w[31:16]); wi = comp(w[15:0]);
        if (inv) wi = -wi;
        tr = (br * wr - bi * wi + 16384) >>> 15;
        ti = (br * wi + bi * wr + 16384) >>> 15;
        x[0] = ar + tr; x[1] = ai + ti;
        x[2] = ar - tr; x[3] = ai - ti;
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc) x[k] = (x[k] + 1) >>> 1;
            if (x[k] > 32767) begin
                x[k] = 32767; e.sat = 1'b1;
            end else if (x[k] < -32768) begin
                x[k] = -32768; e.sat = 1'b1;
            end
            v[k] = x[k];
        end
        e.o0 = {v[0][15:0], v[1][15:0]};
        e.o1 = {v[2][15:0], v[3][15:0]};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Every-cycle compare process and input monitor.
    always @(negedge clk) begin
        chk1("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall && out_valid === 1'b1) begin
            chk("stall_hold_out0", out0, prev0);
            chk("stall_hold_out1", out1, prev1);
        end
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got out0=%h out1=%h, expected no result", out0, out1);
            end else begin
                chk("out0", out0, q[0].o0);
                chk("out1", out1, q[0].o1);
                chk1("ovf", ovf, ovf_acc | q[0].sat);
                if (out_ready) begin
                    $display("result out0=%h out1=%h ovf=%b", out0, out1, ovf);
                    ovf_acc = ovf_acc | q[0].sat;
                    void'(q.pop_front());
                end
            end
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev0 = out0;
        prev1 = out1;
        if (rst) begin
            q.delete();
            ovf_acc = 1'b0;
        end else begin
            if (ovf_clr) begin
                ovf_acc = 1'b0;
                if (out_valid === 1'b1 && !out_ready && q.size() > 0) q[0].sat = 1'b0;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, W, inverse, scale));
                vectors++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                        input bit inv, input bit sc);
        bit ok;
        A = a; B = b; W = w; inverse = inv; scale = sc; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic expect_out(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic eovf, output int waited);
        bit ok;
        ok = 1'b0;
        waited = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (out_valid === 1'b1);
            if (ok) waited = i;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_timeout: got no out_valid in 20 cycles, expected a result", name);
        end else begin
            $display("%s: out0=%h out1=%h ovf=%b", name, out0, out1, ovf);
            chk({name, "_out0"}, out0, e0);
            chk({name, "_out1"}, out1, e1);
            chk1({name, "_ovf"}, ovf, eovf);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rhalf();
        logic [15:0] c[4];
        c[0] = 16'h8000; c[1] = 16'h7FFF; c[2] = 16'h0000; c[3] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    function automatic logic [31:0] rword();
        return {rhalf(), rhalf()};
    endfunction

    initial begin
        int  lat;
        int  sent;
        bit  took;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_out0", out0, 32'h0);
        chk("reset_out1", out1, 32'h0);
        chk1("reset_ovf", ovf, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Case 1: real-only multiply, and the accept-to-valid latency.
        send(pk(1000, 0), pk(2000, 0), pk(32767, 0), 1'b0, 1'b0);
        expect_out("t1", pk(3000, 0), pk(-1000, 0), 1'b0, lat);
        if (lat != 2) begin
            miscompares++;
            $display("FAIL t1_latency: got valid at negedge %0d after accept, expected 2", lat);
        end

        // Case 2: pure imaginary twiddle, forward then inverse.
        send(pk(0, 0), pk(100, 0), pk(0, 32767), 1'b0, 1'b0);
        expect_out("t2_fwd", pk(0, 100), pk(0, -100), 1'b0, lat);
        send(pk(0, 0), pk(100, 0), pk(0, 32767), 1'b1, 1'b0);
        expect_out("t2_inv", pk(0, -100), pk(0, 100), 1'b0, lat);

        // Case 3: positive saturation, clear, then same inputs with scaling.
        send(pk(32767, 0), pk(32767, 0), pk(32767, 0), 1'b0, 1'b0);
        expect_out("t3_sat", pk(32767, 0), pk(1, 0), 1'b1, lat);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk1("t3_ovf_clr", ovf, 1'b0);
        @(posedge clk);
        #1;
        send(pk(32767, 0), pk(32767, 0), pk(32767, 0), 1'b0, 1'b1);
        expect_out("t3_scaled", pk(32767, 0), pk(1, 0), 1'b0, lat);

        // Case 6: negative full scale, (-1)*(-1) product.
        send(pk(-32768, -32768), pk(-32768, 0), pk(-32768, 0), 1'b0, 1'b0);
        expect_out("t6", pk(0, -32768), pk(-32768, -32768), 1'b1, lat);

        // Case 5: reset with two transactions in flight (ovf is set from case 6).
        send(pk(1234, -55), pk(300, 400), pk(20000, -9000), 1'b0, 1'b0);
        send(pk(-777, 888), pk(-300, 50), pk(16384, 16384), 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("t5_out_valid", out_valid, 1'b0);
        chk("t5_out0", out0, 32'h0);
        chk("t5_out1", out1, 32'h0);
        chk1("t5_ovf", ovf, 1'b0);
        chk1("t5_in_ready", in_ready, 1'b1);
        repeat (10) @(posedge clk);
        #1;

        // Case 4: eight random beats, out_ready low for five cycles.
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(rword(), rword(), rword(), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL t4_drain: got %0d results outstanding, expected 0", q.size());
        end

        // Long random run with random gaps and random backpressure.
        sent = 0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                A = rword(); B = rword(); W = rword();
                inverse = 1'($urandom); scale = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            @(posedge clk);
            #1;
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d results outstanding, expected 0", q.size());
        end
        if (sent < 300) begin
            miscompares++;
            $display("FAIL random_throughput: got %0d beats accepted, expected 300", sent);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
